// File: rtl/rep_sequencer.sv
// rep_sequencer: issues one string-element iteration per handshake for
// REP/REPE/REPNE string instructions, stepping ESI/EDI, counting ECX down and
// stopping early on ZF for CMPS/SCAS. Final ECX/ESI/EDI are held for writeback.
// Optional feature macro: REPSEQ_ITER_CAP_EN (bounds each instruction to
// ITER_CAP iterations and flags the cut-off on 'capped').
// Iteration handshake: iter_valid is high for the whole ISSUE state with
// iter_esi/iter_edi stable; an iteration completes in any cycle where
// iter_valid & iter_ready, and zf_in is sampled only in that cycle.
module rep_sequencer #(
    parameter int unsigned ITER_CAP = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  rep_mode,
    input  logic        is_cmp,
    input  logic [1:0]  opnd_size,
    input  logic        df,
    input  logic [31:0] ecx_in,
    input  logic [31:0] esi_in,
    input  logic [31:0] edi_in,
    output logic        iter_valid,
    input  logic        iter_ready,
    output logic [31:0] iter_esi,
    output logic [31:0] iter_edi,
    input  logic        zf_in,
    output logic        busy,
    output logic        done,
    output logic        capped,
    output logic [31:0] ecx_out,
    output logic [31:0] esi_out,
    output logic [31:0] edi_out,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_REPE  = 2'b10;
    localparam logic [1:0] MODE_REPNE = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic        cmp_q, cmp_d;
    logic        df_q, df_d;
    logic [2:0]  step_q, step_d;
    logic [31:0] ecx_q, ecx_d;
    logic [31:0] esi_q, esi_d;
    logic [31:0] edi_q, edi_d;
    logic [31:0] ecx_out_q, ecx_out_d;
    logic [31:0] esi_out_q, esi_out_d;
    logic [31:0] edi_out_q, edi_out_d;
    logic        capped_q, capped_d;
    logic        hs;
    logic        cap_hit;
    logic [31:0] delta;
    logic        term_normal;

    assign hs    = (state_q == S_ISSUE) && iter_ready;
    // Signed step as a 32-bit two's-complement addend; wrap-around is intended.
    assign delta = df_q ? (32'd0 - {29'd0, step_q}) : {29'd0, step_q};

`ifdef REPSEQ_ITER_CAP_EN
    logic [31:0] cnt_q, cnt_d;

    // Iteration counter: cleared on an accepted start, bumped per handshake.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE && start) begin
            cnt_d = '0;
        end else if (hs) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    assign cap_hit = hs && (cnt_d == ITER_CAP);

    // Iteration counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic unused_cap;
    assign unused_cap = ^ITER_CAP;
    assign cap_hit    = 1'b0;
`endif

    // Next-state and working-register update for the sequencer.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cmp_d       = cmp_q;
        df_d        = df_q;
        step_d      = step_q;
        ecx_d       = ecx_q;
        esi_d       = esi_q;
        edi_d       = edi_q;
        ecx_out_d   = ecx_out_q;
        esi_out_d   = esi_out_q;
        edi_out_d   = edi_out_q;
        capped_d    = capped_q;
        term_normal = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = rep_mode;
                    cmp_d  = is_cmp;
                    df_d   = df;
                    case (opnd_size)
                        2'b00:   step_d = 3'd1;
                        2'b01:   step_d = 3'd2;
                        default: step_d = 3'd4;
                    endcase
                    ecx_d = ecx_in;
                    esi_d = esi_in;
                    edi_d = edi_in;
                    if (rep_mode != MODE_NONE && ecx_in == 32'd0) begin
                        state_d   = S_DONE;
                        ecx_out_d = ecx_in;
                        esi_out_d = esi_in;
                        edi_out_d = edi_in;
                        capped_d  = 1'b0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    esi_d = esi_q + delta;
                    edi_d = edi_q + delta;
                    if (mode_q != MODE_NONE) ecx_d = ecx_q - 32'd1;
                    term_normal = (mode_q == MODE_NONE) ||
                                  (ecx_q == 32'd1) ||
                                  (mode_q == MODE_REPE  && cmp_q && !zf_in) ||
                                  (mode_q == MODE_REPNE && cmp_q &&  zf_in);
                    if (term_normal || cap_hit) begin
                        state_d   = S_DONE;
                        ecx_out_d = ecx_d;
                        esi_out_d = esi_d;
                        edi_out_d = edi_d;
                        capped_d  = cap_hit && !term_normal;
                    end
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                capped_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            cmp_q     <= 1'b0;
            df_q      <= 1'b0;
            step_q    <= '0;
            ecx_q     <= '0;
            esi_q     <= '0;
            edi_q     <= '0;
            ecx_out_q <= '0;
            esi_out_q <= '0;
            edi_out_q <= '0;
            capped_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cmp_q     <= cmp_d;
            df_q      <= df_d;
            step_q    <= step_d;
            ecx_q     <= ecx_d;
            esi_q     <= esi_d;
            edi_q     <= edi_d;
            ecx_out_q <= ecx_out_d;
            esi_out_q <= esi_out_d;
            edi_out_q <= edi_out_d;
            capped_q  <= capped_d;
        end
    end

    assign iter_valid = (state_q == S_ISSUE);
    assign iter_esi   = esi_q;
    assign iter_edi   = edi_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign capped     = (state_q == S_DONE) && capped_q;
    assign ecx_out    = ecx_out_q;
    assign esi_out    = esi_out_q;
    assign edi_out    = edi_out_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/rep_sequencer.md
# rep_sequencer

Multi-cycle sequencer for x86 string instructions carrying REP/REPE/REPNE prefixes. It sits in front of the execute stage and issues one string-element iteration at a time to the move unit or the ALU. It owns ECX countdown, ESI/EDI stepping by element size and direction flag, and ZF-based early termination. It then reports the final ECX/ESI/EDI to writeback.

## Interface
Parameters:
- ITER_CAP, 1024: maximum iterations per instruction; used only when REPSEQ_ITER_CAP_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that launches a string instruction; ignored while busy.
- rep_mode  in  2  00 none, 01 REP, 10 REPE, 11 REPNE; sampled on start.
- is_cmp  in  1  instruction is CMPS/SCAS, so ZF termination applies; sampled on start.
- opnd_size  in  2  00 byte (step 1), 01 word (step 2), 10 dword (step 4); 11 is treated as dword.
- df  in  1  EFLAGS.DF; sampled on start. 0 = increment, 1 = decrement.
- ecx_in, esi_in, edi_in  in  32  initial register values; sampled on start.
- iter_valid  out  1  an iteration request is presented to the execute stage.
- iter_ready  in  1  the execute stage completes the presented iteration this cycle.
- iter_esi, iter_edi  out  32  addresses for the current iteration.
- zf_in  in  1  ZF result of the completing iteration; meaningful only when iter_valid & iter_ready.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle completion pulse.
- capped  out  1  the sequence ended on ITER_CAP; valid with done.
- ecx_out, esi_out, edi_out  out  32  final register values; held until the next start.

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE + start:
  - Latch the sampled inputs into the working copies ecx_r, esi_r and edi_r.
  - If rep_mode != 00 and ecx_in == 0, go to DONE with zero iterations.
  - Otherwise go to ISSUE.
- ISSUE:
  - iter_valid = 1, iter_esi = esi_r, iter_edi = edi_r.
  - A handshake is iter_valid & iter_ready.
  - On each handshake:
    - esi_r and edi_r move by ±step, modulo 2^32. Wrap-around is legal and silent.
    - If rep_mode != 00, ecx_r decrements by 1.
  - Terminate on a handshake, moving to DONE, when any of these holds:
    - rep_mode == 00. Exactly one iteration runs and ECX is untouched.
    - ecx_r − 1 == 0.
    - REPE and is_cmp and zf_in == 0.
    - REPNE and is_cmp and zf_in == 1.
  - Otherwise stay in ISSUE.
- DONE:
  - done = 1 for one cycle.
  - ecx_out/esi_out/edi_out = final ecx_r/esi_r/edi_r.
  - Next state is IDLE.
- For REP with is_cmp = 0, zf_in is ignored.
- start asserted in ISSUE or DONE has no effect. It is not queued.

## Timing
- Reset values:
  - State IDLE; busy, iter_valid, done and capped are 0.
  - iter_esi, iter_edi, ecx_out, esi_out and edi_out are 0.
  - All internal registers are 0.
- Reset mid-sequence takes effect immediately (asynchronous). Any in-flight iteration is abandoned, and no done pulse follows.
- start on cycle N:
  - The state leaves IDLE at the edge ending cycle N.
  - iter_valid is first high in cycle N+1; for a zero-count sequence, done is high in cycle N+1.
- busy is high in every ISSUE and DONE cycle.
- Throughput is one iteration per cycle while iter_ready is held high. The updated addresses appear in the cycle after each handshake.
- iter_valid, once high, stays high with stable iter_esi/iter_edi until the handshake.
- Final handshake in cycle M: done is high in cycle M+1, and busy drops in cycle M+2 unless a new start arrives.
- ecx_out/esi_out/edi_out update at the edge entering DONE.

## Configuration
- REPSEQ_ITER_CAP_EN defined:
  - A 32-bit iteration counter clears on start and increments on each handshake.
  - When a handshake brings it to ITER_CAP, the sequence terminates as though a normal termination condition fired.
  - capped = 1 during the DONE cycle only if the cap was the sole reason for termination.
  - ecx_out then reflects the remaining count.
- REPSEQ_ITER_CAP_EN not defined: no counter exists, capped is tied 0, and sequences run unbounded.

## Test plan
- REP, byte, df=0, ecx_in=3, esi_in=0x100, edi_in=0x200, iter_ready=1 -> three iterations at addresses 0x100/0x200, 0x101/0x201, 0x102/0x202; done 4 cycles after start; ecx_out=0, esi_out=0x103, edi_out=0x203.
- REP, dword, df=1, ecx_in=2, esi_in=0x4, edi_in=0x0 -> iter_edi sequence 0x0, 0xFFFFFFFC; esi_out=0xFFFFFFFC, edi_out=0xFFFFFFF8 (wrap-around).
- REP, ecx_in=0 -> iter_valid never asserts; done in cycle N+1; outputs equal the inputs.
- REPE + is_cmp, ecx_in=5, zf_in=1,1,0 -> exactly 3 handshakes; ecx_out=2. The same stimulus with REPNE and zf_in=0,1 -> 2 handshakes, ecx_out=3.
- Backpressure plus reset:
  - Hold iter_ready=0 for 4 cycles -> iter_valid and iter_esi stay stable.
  - Assert rst mid-ISSUE -> busy and iter_valid drop immediately; no done pulse.
  - start asserted while busy is ignored.
- With REPSEQ_ITER_CAP_EN and ITER_CAP=4, REP, ecx_in=10 -> 4 iterations; done with capped=1; ecx_out=6.
